// File: rtl/ccip_txn_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ccip_txn_tracker
// Purpose  : Matches CCI-P requests to responses by mdata tag per channel,
//            measures round-trip latency, flags protocol errors and streams
//            completion/orphan records through buffered valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module ccip_txn_tracker #(
    parameter int NUM_CH        = 2,
    parameter int TAG_W         = 8,
    parameter int TS_W          = 32,
    parameter int LAT_W         = 16,
    parameter int EV_DEPTH      = 16,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic                          clk,
    input  logic                          SoftReset_n,
    input  logic [NUM_CH-1:0]             req_valid,
    input  logic [NUM_CH*TAG_W-1:0]       req_tag,
    input  logic [NUM_CH-1:0]             rsp_valid,
    input  logic [NUM_CH*TAG_W-1:0]       rsp_tag,
    input  logic [NUM_CH-1:0]             almfull,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [1:0]                    ev_ch,
    output logic                          ev_kind,
    output logic [TAG_W-1:0]              ev_tag,
    output logic [LAT_W-1:0]              ev_latency,
    output logic [TS_W-1:0]               ev_time,
    output logic [NUM_CH*(TAG_W+1)-1:0]   outstanding,
    output logic [NUM_CH*4-1:0]           err_sticky,
    input  logic                          clear_err
);

    localparam int c_ENTRIES = 1 << TAG_W;
    localparam int c_PTR_W   = $clog2(EV_DEPTH);
    localparam int c_REC_W   = 1 + TAG_W + LAT_W + TS_W;
    localparam int c_AF_W    = $clog2(ALMFULL_SLACK + 2);
    localparam logic [c_AF_W-1:0] c_AF_MAX   = c_AF_W'(ALMFULL_SLACK + 1);
    localparam logic [c_AF_W-1:0] c_AF_SLACK = c_AF_W'(ALMFULL_SLACK);

    logic [TS_W-1:0]     r_ts;
    logic [c_REC_W-1:0]  w_head [NUM_CH];
    logic [NUM_CH-1:0]   w_nonempty;
    logic [NUM_CH-1:0]   w_pop;
    logic [3:0]          w_ne_pad;
    logic [1:0]          w_grant;
    logic [1:0]          w_pick;
    logic [2:0]          w_idx;
    logic                w_any;
    logic                w_handshake;
    logic [c_REC_W-1:0]  w_sel_rec;
    logic [1:0]          r_rr_ptr;
    logic [1:0]          r_lock_ch;
    logic                r_locked;

    always_ff @(posedge clk) begin
        if (!SoftReset_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [TAG_W-1:0]    w_req_tag;
        logic [TAG_W-1:0]    w_rsp_tag;
        logic [c_ENTRIES-1:0] r_valid;
        logic [TS_W-1:0]     r_issue_ts [c_ENTRIES];
        logic [TAG_W:0]      r_outstanding;
        logic [c_AF_W-1:0]   r_af_cnt;
        logic [c_AF_W-1:0]   w_af_cnt;
        logic [3:0]          r_err;
        logic [3:0]          w_err_set;
        logic                w_rsp_hit;
        logic                w_req_dup;
        logic                w_req_alloc;
        logic                w_af_viol;
        logic [TS_W-1:0]     w_age;
        logic [LAT_W-1:0]    w_lat_trunc;
        logic                w_lat_ovf;
        logic [LAT_W-1:0]    w_lat;
        logic [c_REC_W-1:0]  r_fifo [EV_DEPTH];
        logic [c_PTR_W:0]    r_wr_ptr;
        logic [c_PTR_W:0]    r_rd_ptr;
        logic                w_full;
        logic                w_push;
        logic                w_drop;
        logic [c_REC_W-1:0]  w_rec;

        assign w_req_tag = req_tag[c*TAG_W +: TAG_W];
        assign w_rsp_tag = rsp_tag[c*TAG_W +: TAG_W];

        // The response retires its entry before a same-cycle request looks it up.
        assign w_rsp_hit   = rsp_valid[c] & r_valid[w_rsp_tag];
        assign w_req_dup   = req_valid[c] & r_valid[w_req_tag]
                           & ~(w_rsp_hit & (w_rsp_tag == w_req_tag));
        assign w_req_alloc = req_valid[c] & ~w_req_dup;

        assign w_age = r_ts - r_issue_ts[w_rsp_tag];
        if (TS_W > LAT_W) begin : g_lat_sat
            assign w_lat_ovf   = |w_age[TS_W-1:LAT_W];
            assign w_lat_trunc = w_age[LAT_W-1:0];
        end else begin : g_lat_wide
            assign w_lat_ovf   = 1'b0;
            assign w_lat_trunc = LAT_W'(w_age);
        end
        assign w_lat = !w_rsp_hit ? '0 : (w_lat_ovf ? '1 : w_lat_trunc);
        assign w_rec = {~w_rsp_hit, w_rsp_tag, w_lat, r_ts};

        // Count includes the current cycle, so the (SLACK+1)th busy cycle violates.
        assign w_af_cnt  = !almfull[c] ? '0 :
                           (r_af_cnt == c_AF_MAX) ? c_AF_MAX : r_af_cnt + c_AF_W'(1);
        assign w_af_viol = req_valid[c] & (w_af_cnt > c_AF_SLACK);

        assign w_full = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                        (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
        assign w_nonempty[c] = (r_wr_ptr != r_rd_ptr);
        assign w_pop[c]      = w_handshake && (w_grant == 2'(c));
        assign w_push        = rsp_valid[c] & (~w_full | w_pop[c]);
        assign w_drop        = rsp_valid[c] & w_full & ~w_pop[c];
        assign w_head[c]     = r_fifo[r_rd_ptr[c_PTR_W-1:0]];

        assign w_err_set = {w_drop, w_af_viol, rsp_valid[c] & ~w_rsp_hit, w_req_dup};

        always_ff @(posedge clk) begin
            if (!SoftReset_n) begin
                r_valid       <= '0;
                r_outstanding <= '0;
                r_af_cnt      <= '0;
                r_err         <= '0;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
            end else begin
                if (w_rsp_hit) begin
                    r_valid[w_rsp_tag] <= 1'b0;
                end
                if (req_valid[c]) begin
                    r_valid[w_req_tag] <= 1'b1;
                end
                case ({w_req_alloc, w_rsp_hit})
                    2'b10:   r_outstanding <= r_outstanding + (TAG_W+1)'(1);
                    2'b01:   r_outstanding <= r_outstanding - (TAG_W+1)'(1);
                    default: r_outstanding <= r_outstanding;
                endcase
                r_af_cnt <= w_af_cnt;
                r_err    <= (clear_err ? 4'b0000 : r_err) | w_err_set;
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
                end
                if (w_pop[c]) begin
                    r_rd_ptr <= r_rd_ptr + (c_PTR_W+1)'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (req_valid[c]) begin
                r_issue_ts[w_req_tag] <= r_ts;
            end
            if (w_push) begin
                r_fifo[r_wr_ptr[c_PTR_W-1:0]] <= w_rec;
            end
        end

        assign outstanding[c*(TAG_W+1) +: TAG_W+1] = r_outstanding;
        assign err_sticky[c*4 +: 4]                = r_err;
    end

    assign w_ne_pad = 4'(w_nonempty);

    // Round-robin search starting at the pointer; lower offsets win.
    always_comb begin
        w_pick = 2'd0;
        w_any  = 1'b0;
        w_idx  = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_rr_ptr} + 3'(i);
            if (w_idx >= 3'(NUM_CH)) begin
                w_idx = w_idx - 3'(NUM_CH);
            end
            if (w_ne_pad[w_idx[1:0]]) begin
                w_pick = w_idx[1:0];
                w_any  = 1'b1;
            end
        end
    end

    assign w_grant     = r_locked ? r_lock_ch : w_pick;
    assign ev_valid    = w_any;
    assign w_handshake = ev_valid & ev_ready;

    always_comb begin
        w_sel_rec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant == 2'(i)) begin
                w_sel_rec = w_head[i];
            end
        end
    end

    assign ev_ch = ev_valid ? w_grant : 2'd0;
    assign {ev_kind, ev_tag, ev_latency, ev_time} = ev_valid ? w_sel_rec : '0;

    // A stalled grant is locked so a newly non-empty channel cannot displace it.
    always_ff @(posedge clk) begin
        if (!SoftReset_n) begin
            r_rr_ptr  <= 2'd0;
            r_locked  <= 1'b0;
            r_lock_ch <= 2'd0;
        end else if (w_handshake) begin
            r_locked <= 1'b0;
            r_rr_ptr <= (w_grant == 2'(NUM_CH - 1)) ? 2'd0 : w_grant + 2'd1;
        end else if (ev_valid) begin
            r_locked  <= 1'b1;
            r_lock_ch <= w_grant;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccip_txn_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccip_txn_tracker
// Purpose  : Directed self-checking bench for ccip_txn_tracker.
// Revision : 1.0  initial release
// ============================================================================
module tb_ccip_txn_tracker;

    localparam int NUM_CH        = 2;
    localparam int TAG_W         = 8;
    localparam int TS_W          = 32;
    localparam int LAT_W         = 16;
    localparam int EV_DEPTH      = 16;
    localparam int ALMFULL_SLACK = 8;

    logic                        clk = 1'b0;
    logic                        SoftReset_n;
    logic [NUM_CH-1:0]           req_valid;
    logic [NUM_CH*TAG_W-1:0]     req_tag;
    logic [NUM_CH-1:0]           rsp_valid;
    logic [NUM_CH*TAG_W-1:0]     rsp_tag;
    logic [NUM_CH-1:0]           almfull;
    logic                        ev_valid;
    logic                        ev_ready;
    logic [1:0]                  ev_ch;
    logic                        ev_kind;
    logic [TAG_W-1:0]            ev_tag;
    logic [LAT_W-1:0]            ev_latency;
    logic [TS_W-1:0]             ev_time;
    logic [NUM_CH*(TAG_W+1)-1:0] outstanding;
    logic [NUM_CH*4-1:0]         err_sticky;
    logic                        clear_err;

    int checks   = 0;
    int failures = 0;
    int exp_ts   = 0;
    int t_mark   = 0;

    ccip_txn_tracker #(
        .NUM_CH        (NUM_CH),
        .TAG_W         (TAG_W),
        .TS_W          (TS_W),
        .LAT_W         (LAT_W),
        .EV_DEPTH      (EV_DEPTH),
        .ALMFULL_SLACK (ALMFULL_SLACK)
    ) u_dut (
        .clk         (clk),
        .SoftReset_n (SoftReset_n),
        .req_valid   (req_valid),
        .req_tag     (req_tag),
        .rsp_valid   (rsp_valid),
        .rsp_tag     (rsp_tag),
        .almfull     (almfull),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_ch       (ev_ch),
        .ev_kind     (ev_kind),
        .ev_tag      (ev_tag),
        .ev_latency  (ev_latency),
        .ev_time     (ev_time),
        .outstanding (outstanding),
        .err_sticky  (err_sticky),
        .clear_err   (clear_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // exp_ts tracks the timestamp the DUT will sample at the next edge.
    task automatic step();
        @(posedge clk);
        if (SoftReset_n) exp_ts++;
        else exp_ts = 0;
        #1;
    endtask

    task automatic idle_until(input int t);
        while (exp_ts < t) step();
    endtask

    task automatic clr();
        req_valid = '0;
        rsp_valid = '0;
        clear_err = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        step();
        clr();
    endtask

    initial begin
        SoftReset_n = 1'b0;
        req_tag     = '0;
        rsp_tag     = '0;
        almfull     = '0;
        ev_ready    = 1'b1;
        clr();
        step();
        step();

        check_eq("rst_ev_valid", ev_valid, 0);
        check_eq("rst_ev_payload", {ev_ch, ev_kind, ev_tag, ev_latency, ev_time}, 0);
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_err", err_sticky, 0);

        // Basic completion: issue at ts=10, respond at ts=17.
        SoftReset_n = 1'b1;
        idle_until(10);
        req_valid = 2'b01; req_tag = {8'h00, 8'h05};
        step(); clr();
        check_eq("t1_out_after_req", outstanding[8:0], 1);
        idle_until(17);
        rsp_valid = 2'b01; rsp_tag = {8'h00, 8'h05};
        step(); clr();
        check_eq("t1_valid", ev_valid, 1);
        check_eq("t1_ch", ev_ch, 0);
        check_eq("t1_kind", ev_kind, 0);
        check_eq("t1_tag", ev_tag, 8'h05);
        check_eq("t1_lat", ev_latency, 7);
        check_eq("t1_time", ev_time, 17);
        check_eq("t1_out_after_rsp", outstanding[8:0], 0);
        step();
        check_eq("t1_drained", ev_valid, 0);

        // Orphan on ch1, clear, then orphan with a simultaneous clear.
        rsp_valid = 2'b10; rsp_tag = {8'h22, 8'h00}; t_mark = exp_ts;
        step(); clr();
        check_eq("t2_valid", ev_valid, 1);
        check_eq("t2_ch", ev_ch, 1);
        check_eq("t2_kind", ev_kind, 1);
        check_eq("t2_tag", ev_tag, 8'h22);
        check_eq("t2_lat", ev_latency, 0);
        check_eq("t2_time", ev_time, 64'(t_mark));
        check_eq("t2_err", err_sticky, 8'h20);
        step();
        pulse_clear();
        check_eq("t2_cleared", err_sticky, 0);
        rsp_valid = 2'b10; rsp_tag = {8'h22, 8'h00}; clear_err = 1'b1;
        step(); clr();
        check_eq("t2_set_wins", err_sticky, 8'h20);
        step();
        pulse_clear();

        // Duplicate request: latency measured from the second issue.
        req_valid = 2'b01; req_tag = {8'h00, 8'h03};
        step(); clr();
        step(); step();
        req_valid = 2'b01; req_tag = {8'h00, 8'h03};
        step(); clr();
        check_eq("t3_dup_err", err_sticky, 8'h01);
        check_eq("t3_out", outstanding[8:0], 1);
        repeat (3) step();
        rsp_valid = 2'b01; rsp_tag = {8'h00, 8'h03};
        step(); clr();
        check_eq("t3_kind", ev_kind, 0);
        check_eq("t3_lat", ev_latency, 4);
        check_eq("t3_out_after", outstanding[8:0], 0);
        step();
        pulse_clear();

        // Same-cycle response and request on one tag, then minimum latency.
        req_valid = 2'b01; req_tag = {8'h00, 8'h09};
        step(); clr();
        repeat (3) step();
        req_valid = 2'b01; req_tag = {8'h00, 8'h09};
        rsp_valid = 2'b01; rsp_tag = {8'h00, 8'h09};
        step(); clr();
        check_eq("t3b_kind", ev_kind, 0);
        check_eq("t3b_lat", ev_latency, 4);
        check_eq("t3b_out", outstanding[8:0], 1);
        check_eq("t3b_no_err", err_sticky, 0);
        rsp_valid = 2'b01; rsp_tag = {8'h00, 8'h09};
        step(); clr();
        check_eq("t3b_min_lat", ev_latency, 1);
        check_eq("t3b_out_after", outstanding[8:0], 0);
        step();

        // Overflow the ch0 FIFO while stalled, then drain in order.
        ev_ready = 1'b0;
        t_mark   = exp_ts;
        for (int i = 0; i < 17; i++) begin
            rsp_valid = 2'b01; rsp_tag = {8'h00, 8'(8'h40 + i)};
            step();
        end
        clr();
        check_eq("t4_err", err_sticky, 8'h0A);
        check_eq("t4_head_tag", ev_tag, 8'h40);
        check_eq("t4_head_time", ev_time, 64'(t_mark));
        repeat (2) step();
        check_eq("t4_stall_valid", ev_valid, 1);
        check_eq("t4_stall_tag", ev_tag, 8'h40);
        ev_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("t4_drain_valid", ev_valid, 1);
            check_eq("t4_drain_tag", ev_tag, 64'(32'h40 + i));
            check_eq("t4_drain_time", ev_time, 64'(t_mark + i));
            step();
        end
        check_eq("t4_empty", ev_valid, 0);
        pulse_clear();

        // Almost-full: 8th busy cycle tolerated, 9th is a violation.
        almfull = 2'b10;
        repeat (7) step();
        req_valid = 2'b10; req_tag = {8'h11, 8'h00};
        step(); clr();
        check_eq("t6_af_cycle8", err_sticky[6], 0);
        req_valid = 2'b10; req_tag = {8'h12, 8'h00};
        step(); clr();
        check_eq("t6_af_cycle9", err_sticky[6], 1);
        check_eq("t6_out_ch1", outstanding[17:9], 2);
        almfull = 2'b00;

        // Reset with live entries and a queued event.
        ev_ready = 1'b0;
        rsp_valid = 2'b01; rsp_tag = {8'h00, 8'h77};
        step(); clr();
        check_eq("t7_queued", ev_valid, 1);
        SoftReset_n = 1'b0;
        step();
        check_eq("t7_rst_valid", ev_valid, 0);
        check_eq("t7_rst_payload", {ev_ch, ev_kind, ev_tag, ev_latency, ev_time}, 0);
        check_eq("t7_rst_out", outstanding, 0);
        check_eq("t7_rst_err", err_sticky, 0);
        SoftReset_n = 1'b1;
        ev_ready = 1'b1;
        rsp_valid = 2'b10; rsp_tag = {8'h11, 8'h00};
        step(); clr();
        check_eq("t7_old_tag_kind", ev_kind, 1);
        check_eq("t7_old_tag_ch", ev_ch, 1);
        check_eq("t7_old_tag_time", ev_time, 0);
        check_eq("t7_old_tag_err", err_sticky, 8'h20);
        step();
        pulse_clear();

        // Both channels every cycle: strict alternation starting at ch0.
        for (int n = 0; n < 12; n++) begin
            if (n < 6) begin
                rsp_valid = 2'b11;
                rsp_tag   = {8'(8'h70 + n), 8'(8'h60 + n)};
            end else begin
                clr();
            end
            step();
            check_eq("t5_valid", ev_valid, 1);
            check_eq("t5_ch", ev_ch, 64'(n % 2));
            check_eq("t5_tag", ev_tag, 64'(((n % 2) != 0 ? 32'h70 : 32'h60) + n / 2));
        end
        clr();
        step();
        check_eq("t5_empty", ev_valid, 0);
        check_eq("t5_no_drop", err_sticky, 8'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccip_txn_tracker.md
# ccip_txn_tracker

Parametrised CCI-P transaction tracker, the synthesizable successor to the ASE transaction logger. It sits on the AFU-side CCI-P tap and matches requests to responses by mdata tag across NUM_CH independent request/response channel pairs. For every response it measures round-trip latency, flags protocol errors, and streams completion and error records through a buffered valid/ready port, so an on-chip or simulation logger can drain them without stalling the bus.

## Interface
- NUM_CH, 2: request/response channel pairs tracked (1..4).
- TAG_W, 8: low mdata bits used as tag; the scoreboard has 2^TAG_W entries per channel.
- TS_W, 32: free-running timestamp width.
- LAT_W, 16: latency field width; the value saturates.
- EV_DEPTH, 16: per-channel event FIFO depth (power of 2, ≥2).
- ALMFULL_SLACK, 8: cycles of continuous almost-full before a request counts as a violation.

- clk  in  1  clock; all state is on the rising edge.
- SoftReset_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_CH  request issued on channel c.
- req_tag  in  NUM_CH*TAG_W  request tag, channel c at [c*TAG_W +: TAG_W].
- rsp_valid  in  NUM_CH  response received on channel c.
- rsp_tag  in  NUM_CH*TAG_W  response tag.
- almfull  in  NUM_CH  TxAlmFull for channel c.
- ev_valid  out  1  event record available.
- ev_ready  in  1  consumer accepts the record.
- ev_ch  out  2  source channel.
- ev_kind  out  1  0 = completion, 1 = orphan response.
- ev_tag  out  TAG_W  tag.
- ev_latency  out  LAT_W  response cycle minus issue cycle; 0 for an orphan.
- ev_time  out  TS_W  timestamp of the response cycle.
- outstanding  out  NUM_CH*(TAG_W+1)  live entry count per channel.
- err_sticky  out  NUM_CH*4  per channel: [0] duplicate tag, [1] orphan response, [2] almfull violation, [3] event dropped.
- clear_err  in  1  pulse; clears err_sticky.

## Operation
- Timestamp: ts counts up by 1 every cycle and wraps at 2^TS_W.
- Scoreboard per channel: one valid bit per tag, plus the issue timestamp.
- Response on channel c, tag t:
  - If entry t is valid: clear it, decrement outstanding, and enqueue a completion event.
  - Latency = (ts − issue_ts) mod 2^TS_W. If it exceeds 2^LAT_W−1, report all-ones.
  - If entry t is invalid: enqueue an orphan event and set err[1].
- Request on channel c, tag t:
  - If entry t is already valid: set err[0], overwrite the timestamp, and leave outstanding unchanged.
  - Otherwise: set valid, store ts, and increment outstanding.
- Same cycle, same channel, same tag: the response is processed first, then the request allocates. The result is one completion (or an orphan) and a live entry, with outstanding net unchanged (+1 if orphan).
- Almost-full violation:
  - A per-channel counter increments while almfull=1, saturates at ALMFULL_SLACK+1, and resets to 0 when almfull=0.
  - A request in a cycle where the counter is greater than ALMFULL_SLACK sets err[2]. The request is still tracked.
- Event FIFOs:
  - Each channel has a show-ahead FIFO and generates at most one event per cycle.
  - If the FIFO is full, the event is discarded and err[3] is set. Scoreboard updates still occur.
- Output arbiter:
  - Round-robin over non-empty FIFOs; the pointer starts at channel 0 after reset.
  - On a handshake (ev_valid & ev_ready), the pointer moves to the channel after the granted one.
  - Once ev_valid is asserted, the grant and payload are held until the handshake.
- clear_err clears all sticky bits. If an error occurs in the same cycle, the set wins.

## Timing
- Reset (SoftReset_n=0 at an edge) leaves the following state:
  - Outputs: ev_valid=0, ev_ch/ev_kind/ev_tag/ev_latency/ev_time=0, outstanding=0, err_sticky=0.
  - Internal: ts=0, all valid bits cleared, FIFOs empty, almfull counters=0.
- Reset mid-operation discards all tracked entries and queued events. Responses arriving after reset are reported as orphans.
- Inputs are sampled at edge k. Scoreboard, outstanding, and err_sticky reflect the sample after edge k.
- An event sampled at edge k appears on ev_valid after edge k (next cycle) if its FIFO was empty and it is granted. ev_time equals the ts value in the sampling cycle.
- A request at cycle i with its response at cycle j gives ev_latency = j−i. The minimum is 1, since the same-cycle case is processed response-first.
- Throughput: one event per cycle on output. A simultaneous FIFO push and pop on a full FIFO is accepted without a drop.

## Test plan
- Request ch0 tag 0x05 at ts=10, response ch0 tag 0x05 at ts=17 → one event {ch0, kind 0, tag 05, latency 7, time 17}; outstanding[0] goes 0→1→0.
- Response ch1 tag 0x22 with no request → event {kind 1, latency 0}; err[1] of ch1 set; clear_err → cleared. Then repeat with clear_err in the same cycle as the orphan → stays set.
- Request tag 3 twice on ch0 without a response → err[0] set, outstanding=1; response latency measured from the second issue.
- Hold ev_ready=0 and send 17 responses on ch0 with EV_DEPTH=16 → the 17th is dropped and err[3] set. Release ev_ready → exactly 16 events drain in order; the payload is stable while stalled.
- Responses on ch0 and ch1 every cycle with ev_ready=1 → output alternates ch0, ch1, … starting with ch0; no drops.
- Hold almfull[1]=1 for 9 cycles, request on cycle 9 (counter=9 > 8) → err[2] set; a request on cycle 8 → not set. Assert reset mid-stream → all outputs 0 the next cycle, and an old tag's response becomes an orphan.
